eth_tx_arb: RTL and testbench
=============================

ETH_TX_ARB -- requirements
Module: eth_tx_arb

Interface
REQ-001 Parameter NREQ, default 4, number of frame requesters (2..8).
REQ-002 Parameter IFG_CYC, default 96, inter-frame gap in clk cycles (96 bit times at 100 MHz clk, RMII half-rate).
REQ-003 clk  in  1  system clock, 100 MHz.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 req  in  NREQ  per-requester level request; frame ready in requester buffer.
REQ-006 req_last  in  NREQ*11  per-requester index of last frame byte (byte count minus 1).
REQ-007 gnt  out  NREQ  one-hot grant; high from frame launch until done.
REQ-008 done  out  NREQ  one-cycle pulse on frame completion for the granted requester.
REQ-009 err  out  1  one-cycle pulse on MAC start timeout.
REQ-010 rd_addr  out  11  buffer read address broadcast to all requesters; equals mac_tx_addr.
REQ-011 rd_data  in  NREQ*8  per-requester buffer byte for rd_addr, combinational.
REQ-012 mac_tx_vld  out  1  one-cycle frame start strobe to MAC.
REQ-013 mac_tx_count  out  11  last byte index for MAC.
REQ-014 mac_tx_addr  in  11  MAC read address.
REQ-015 mac_tx_busy  in  1  MAC busy; rises 1 cycle after mac_tx_vld, falls after FCS.
REQ-016 mac_tx_data  out  8  byte to MAC.

Function
REQ-017 FSM states: IDLE, LAUNCH, WAIT_BUSY, SEND, GAP.
REQ-018 IDLE: req sampled only here; any req bit set -> LAUNCH next cycle, winner latched, gnt asserted.
REQ-019 Winner = lowest index at or after rr pointer (wrapping); rr pointer = winner+1 mod NREQ, updated at LAUNCH; reset pointer 0.
REQ-020 LAUNCH: mac_tx_vld=1 for exactly one cycle; mac_tx_count = max(latched req_last, 59) -> WAIT_BUSY.
REQ-021 WAIT_BUSY: mac_tx_busy=1 -> SEND; not seen within 15 cycles -> err pulse, gnt cleared, no done, -> GAP.
REQ-022 SEND: mac_tx_busy falling to 0 -> done[winner] pulse same cycle as gnt clears -> GAP.
REQ-023 GAP: counter counts IFG_CYC cycles, then -> IDLE; req ignored during GAP.
REQ-024 mac_tx_data = rd_data[winner] when mac_tx_addr <= latched req_last, else 8'h00 (min-frame padding); 8'h00 when no grant.
REQ-025 req_last and winner latched at LAUNCH; later changes to req/req_last ignored until IDLE.
REQ-026 req dropping while granted: frame still completes, done still pulses.
REQ-027 Back-to-back: requester holding req after done is re-granted only if no other requester is pending at next IDLE (rr fairness).
REQ-028 Outputs mac_tx_vld, gnt, done, err registered.

Reset
REQ-029 reset in any state: FSM -> IDLE, gnt=0, done=0, err=0, mac_tx_vld=0, mac_tx_count=0, rr pointer=0, GAP counter=0 next cycle.
REQ-030 Reset mid-frame aborts without done pulse; MAC shares same reset.

Structure
REQ-031 Shared package eth_pkg holds ETH_MIN_LAST=59, IFG_CYC default, WAIT_BUSY timeout 15, and the FSM state enum.
REQ-032 Sub-module eth_rr_pick: combinational round-robin winner select (req, pointer -> one-hot winner, valid).

Verification
REQ-033 req=4'b0001, req_last=99 -> one mac_tx_vld, mac_tx_count=99, gnt=0001, done[0] at busy fall, IDLE after 96 gap cycles.
REQ-034 req=4'b1111 held continuously -> grant order 0,1,2,3,0 with >=96 cycles between busy fall and next mac_tx_vld.
REQ-035 req_last=20 -> mac_tx_count=59; mac_tx_data=00 for mac_tx_addr 21..59, rd_data for 0..20.
REQ-036 MAC model never asserts busy -> err pulse 15 cycles after WAIT_BUSY entry, no done, gnt cleared.
REQ-037 reset asserted mid-SEND -> gnt=0, no done, next req=0010 granted from pointer 0 after reset.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared constants and FSM state type for the Ethernet TX frame arbiter.
package eth_pkg;

    localparam int ETH_MIN_LAST = 59;   // 60-byte minimum frame before FCS
    localparam int IFG_CYC_DEF  = 96;
    localparam int WAIT_BUSY_TO = 15;
    localparam int ADDR_W       = 11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT_BUSY,
        ST_SEND,
        ST_GAP
    } arb_state_t;

    function automatic logic [ADDR_W-1:0] pad_last(input logic [ADDR_W-1:0] last);
        return (last < ADDR_W'(ETH_MIN_LAST)) ? ADDR_W'(ETH_MIN_LAST) : last;
    endfunction

endpackage

// File: rtl/eth_rr_pick.sv
// Combinational round-robin select: first requester at or after the pointer, wrapping.
module eth_rr_pick #(
    parameter int NREQ = 4,
    parameter int PW   = 2
)(
    input  logic [NREQ-1:0] i_req,
    input  logic [PW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_onehot,
    output logic [PW-1:0]   o_idx,
    output logic            o_vld
);

    always_comb begin : pick
        int unsigned j;
        j        = 0;
        o_onehot = '0;
        o_idx    = '0;
        o_vld    = 1'b0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            j = (32'(i_ptr) + k) % NREQ;
            if (!o_vld && i_req[j]) begin
                o_vld       = 1'b1;
                o_idx       = PW'(j);
                o_onehot[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/eth_tx_arb.sv
// Round-robin arbiter launching buffered frames into a single Ethernet MAC,
// with start timeout, minimum-frame padding and inter-frame gap.
module eth_tx_arb
    import eth_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int IFG_CYC = IFG_CYC_DEF
)(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*11-1:0]   req_last,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      done,
    output logic                 err,
    output logic [10:0]          rd_addr,
    input  logic [NREQ*8-1:0]    rd_data,
    output logic                 mac_tx_vld,
    output logic [10:0]          mac_tx_count,
    input  logic [10:0]          mac_tx_addr,
    input  logic                 mac_tx_busy,
    output logic [7:0]           mac_tx_data
);

    localparam int PW = $clog2(NREQ);
    localparam int GW = $clog2(IFG_CYC + 1);
    localparam int TW = $clog2(WAIT_BUSY_TO + 1);

    arb_state_t      r_state;
    logic [PW-1:0]   r_ptr;
    logic [PW-1:0]   r_win;
    logic [10:0]     r_last;
    logic [GW-1:0]   r_gap;
    logic [TW-1:0]   r_tmo;
    logic [NREQ-1:0] r_gnt;
    logic [NREQ-1:0] r_done;
    logic            r_err;
    logic            r_vld;
    logic [10:0]     r_count;

    logic [NREQ-1:0] w_pick_onehot;
    logic [PW-1:0]   w_pick_idx;
    logic            w_pick_vld;
    logic [10:0]     w_last_sel;
    logic [PW-1:0]   w_ptr_next;

    eth_rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .i_req    (req),
        .i_ptr    (r_ptr),
        .o_onehot (w_pick_onehot),
        .o_idx    (w_pick_idx),
        .o_vld    (w_pick_vld)
    );

    assign w_last_sel = req_last[w_pick_idx*11 +: 11];
    assign w_ptr_next = (w_pick_idx == PW'(NREQ - 1)) ? '0 : w_pick_idx + PW'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_win   <= '0;
            r_last  <= '0;
            r_gap   <= '0;
            r_tmo   <= '0;
            r_gnt   <= '0;
            r_done  <= '0;
            r_err   <= 1'b0;
            r_vld   <= 1'b0;
            r_count <= '0;
        end else begin
            r_vld  <= 1'b0;
            r_done <= '0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_vld) begin
                        r_win   <= w_pick_idx;
                        r_last  <= w_last_sel;
                        r_gnt   <= w_pick_onehot;
                        r_vld   <= 1'b1;
                        r_count <= pad_last(w_last_sel);
                        r_ptr   <= w_ptr_next;
                        r_state <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    r_tmo   <= '0;
                    r_state <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    if (mac_tx_busy) begin
                        r_state <= ST_SEND;
                    end else if (r_tmo == TW'(WAIT_BUSY_TO - 1)) begin
                        r_err   <= 1'b1;
                        r_gnt   <= '0;
                        r_gap   <= '0;
                        r_state <= ST_GAP;
                    end else begin
                        r_tmo <= r_tmo + TW'(1);
                    end
                end
                ST_SEND: begin
                    if (!mac_tx_busy) begin
                        r_done  <= r_gnt;
                        r_gnt   <= '0;
                        r_gap   <= '0;
                        r_state <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (r_gap == GW'(IFG_CYC - 1)) begin
                        r_gap   <= '0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_gap <= r_gap + GW'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Bytes past the requester's last index are zero padding up to the minimum frame.
    always_comb begin
        mac_tx_data = '0;
        if (r_gnt != '0 && mac_tx_addr <= r_last)
            mac_tx_data = rd_data[r_win*8 +: 8];
    end

    assign rd_addr      = mac_tx_addr;
    assign gnt          = r_gnt;
    assign done         = r_done;
    assign err          = r_err;
    assign mac_tx_vld   = r_vld;
    assign mac_tx_count = r_count;

endmodule

// File: tb/tb_eth_tx_arb.sv
// Self-checking bench for eth_tx_arb: MAC model, round-robin reference and per-byte data checks.
module tb_eth_tx_arb;

    localparam int NREQ = 4;
    localparam int IFG  = 96;
    localparam int MINL = 59;
    localparam int TMO  = 15;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NREQ-1:0]      req;
    logic [NREQ*11-1:0]   req_last;
    logic [NREQ-1:0]      gnt;
    logic [NREQ-1:0]      done;
    logic                 err;
    logic [10:0]          rd_addr;
    logic [NREQ*8-1:0]    rd_data;
    logic                 mac_tx_vld;
    logic [10:0]          mac_tx_count;
    logic [10:0]          mac_tx_addr;
    logic                 mac_tx_busy;
    logic [7:0]           mac_tx_data;

    int unsigned cyc = 0;
    int unsigned done_cyc = 0;
    int tests = 0;
    int fails = 0;
    int m_ptr = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    eth_tx_arb #(
        .NREQ    (NREQ),
        .IFG_CYC (IFG)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .req_last     (req_last),
        .gnt          (gnt),
        .done         (done),
        .err          (err),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .mac_tx_vld   (mac_tx_vld),
        .mac_tx_count (mac_tx_count),
        .mac_tx_addr  (mac_tx_addr),
        .mac_tx_busy  (mac_tx_busy),
        .mac_tx_data  (mac_tx_data)
    );

    // Buffer contents always have bit 7 set so zero padding is distinguishable.
    function automatic logic [7:0] byte_of(input int r, input int a);
        return {1'b1, 7'((r * 19 + a * 7) & 127)};
    endfunction

    always_comb begin
        for (int r = 0; r < NREQ; r++)
            rd_data[r*8 +: 8] = byte_of(r, int'(rd_addr));
    end

    function automatic int pick(input logic [NREQ-1:0] m, input int p);
        for (int k = 0; k < NREQ; k++)
            if (m[(p + k) % NREQ]) return (p + k) % NREQ;
        return -1;
    endfunction

    function automatic int last_of(input int r);
        return int'(req_last[r*11 +: 11]);
    endfunction

    task automatic set_last(input int r, input int v);
        req_last[r*11 +: 11] = 11'(v);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic run_frame(input int win, input int last, input bit chk_gap, input bit drop);
        int n;
        int exp_cnt;
        bit bad;
        logic [NREQ-1:0] exp_g;
        logic [7:0] exp_d;
        exp_g = NREQ'(1) << win;
        n = 0;
        while (!mac_tx_vld && n < 400) begin
            step;
            n++;
        end
        tests++;
        if (mac_tx_vld !== 1'b1) begin
            fails++;
            $display("FAIL launch: mac_tx_vld=%b required 1 within 400 cycles", mac_tx_vld);
            return;
        end
        if (chk_gap) begin
            tests++;
            if (cyc - done_cyc != IFG + 1) begin
                fails++;
                $display("FAIL gap: done-to-vld %0d cycles required %0d", cyc - done_cyc, IFG + 1);
            end
        end
        exp_cnt = (last < MINL) ? MINL : last;
        tests++;
        if (gnt !== exp_g) begin
            fails++;
            $display("FAIL gnt: gnt=%b required %b", gnt, exp_g);
        end
        tests++;
        if (mac_tx_count !== 11'(exp_cnt)) begin
            fails++;
            $display("FAIL count: mac_tx_count=%0d required %0d", mac_tx_count, exp_cnt);
        end
        m_ptr = (win + 1) % NREQ;
        if (drop) begin
            req = '0;
            for (int r = 0; r < NREQ; r++) set_last(r, $urandom_range(0, 2000));
        end
        step;
        tests++;
        if (mac_tx_vld !== 1'b0) begin
            fails++;
            $display("FAIL vld_pulse: mac_tx_vld=%b required 0 one cycle after launch", mac_tx_vld);
        end
        mac_tx_busy = 1'b1;
        bad = 1'b0;
        for (int a = 0; a <= exp_cnt; a++) begin
            step;
            mac_tx_addr = 11'(a);
            #1;
            exp_d = (a <= last) ? byte_of(win, a) : 8'h00;
            tests++;
            if (mac_tx_data !== exp_d) begin
                fails++;
                $display("FAIL data: addr %0d mac_tx_data=%h required %h", a, mac_tx_data, exp_d);
            end
            if (done !== '0 || gnt !== exp_g) bad = 1'b1;
        end
        for (int f = 0; f < 4; f++) begin
            step;
            if (done !== '0 || gnt !== exp_g) bad = 1'b1;
        end
        tests++;
        if (bad) begin
            fails++;
            $display("FAIL send_hold: done/gnt changed during SEND, required done=0 gnt=%b", exp_g);
        end
        mac_tx_busy = 1'b0;
        mac_tx_addr = 11'd5;
        step;
        done_cyc = cyc;
        tests++;
        if (done !== exp_g) begin
            fails++;
            $display("FAIL done: done=%b required %b", done, exp_g);
        end
        tests++;
        if (gnt !== '0) begin
            fails++;
            $display("FAIL gnt_clear: gnt=%b required 0", gnt);
        end
        tests++;
        if (mac_tx_data !== 8'h00) begin
            fails++;
            $display("FAIL idle_data: mac_tx_data=%h required 00", mac_tx_data);
        end
        step;
        tests++;
        if (done !== '0) begin
            fails++;
            $display("FAIL done_pulse: done=%b required 0", done);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        req = '0;
        req_last = '0;
        mac_tx_busy = 1'b0;
        mac_tx_addr = 11'd3;
        step;
        step;
        tests++;
        if ({gnt, done, err, mac_tx_vld} !== '0 || mac_tx_count !== 11'd0) begin
            fails++;
            $display("FAIL reset_out: gnt=%b done=%b err=%b vld=%b count=%0d required all 0",
                     gnt, done, err, mac_tx_vld, mac_tx_count);
        end
        tests++;
        if (mac_tx_data !== 8'h00) begin
            fails++;
            $display("FAIL reset_data: mac_tx_data=%h required 00", mac_tx_data);
        end
        reset = 1'b0;
        mac_tx_addr = '0;
        m_ptr = 0;
        step;
    endtask

    task automatic test_rr;
        int w;
        for (int r = 0; r < NREQ; r++) set_last(r, $urandom_range(0, 120));
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            w = pick(req, m_ptr);
            run_frame(w, last_of(w), i > 0, 1'b0);
        end
    endtask

    task automatic test_single;
        req = 4'b0001;
        set_last(0, 99);
        run_frame(pick(req, m_ptr), 99, 1'b1, 1'b0);
    endtask

    task automatic test_pad;
        req = 4'b0010;
        set_last(1, 20);
        run_frame(pick(req, m_ptr), 20, 1'b1, 1'b0);
    endtask

    task automatic test_random;
        logic [NREQ-1:0] mask;
        int w;
        for (int i = 0; i < 12; i++) begin
            mask = NREQ'($urandom_range(1, 15));
            for (int r = 0; r < NREQ; r++) set_last(r, $urandom_range(0, 150));
            req = mask;
            w = pick(mask, m_ptr);
            run_frame(w, last_of(w), 1'b1, 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_timeout;
        int n;
        bit bad;
        logic [NREQ-1:0] exp_g;
        req = 4'b0100;
        exp_g = NREQ'(1) << pick(req, m_ptr);
        n = 0;
        while (!mac_tx_vld && n < 400) begin
            step;
            n++;
        end
        tests++;
        if (mac_tx_vld !== 1'b1 || gnt !== exp_g) begin
            fails++;
            $display("FAIL tmo_launch: vld=%b gnt=%b required 1 %b", mac_tx_vld, gnt, exp_g);
        end
        m_ptr = (pick(req, m_ptr) + 1) % NREQ;
        req = '0;
        bad = 1'b0;
        for (int k = 1; k <= TMO + 1; k++) begin
            step;
            if (done !== '0) bad = 1'b1;
            if (k == TMO) begin
                tests++;
                if (err !== 1'b0 || gnt !== exp_g) begin
                    fails++;
                    $display("FAIL tmo_early: err=%b gnt=%b required 0 %b", err, gnt, exp_g);
                end
            end
        end
        tests++;
        if (err !== 1'b1 || gnt !== '0) begin
            fails++;
            $display("FAIL tmo_err: err=%b gnt=%b required 1 0000", err, gnt);
        end
        step;
        if (done !== '0) bad = 1'b1;
        tests++;
        if (err !== 1'b0) begin
            fails++;
            $display("FAIL tmo_pulse: err=%b required 0", err);
        end
        for (int k = 0; k < IFG + 10; k++) begin
            step;
            if (done !== '0 || mac_tx_vld !== 1'b0) bad = 1'b1;
        end
        tests++;
        if (bad) begin
            fails++;
            $display("FAIL tmo_quiet: done or vld asserted after timeout, required none");
        end
    endtask

    task automatic test_reset_mid;
        int n;
        bit bad;
        req = 4'b0100;
        set_last(2, 80);
        n = 0;
        while (!mac_tx_vld && n < 400) begin
            step;
            n++;
        end
        tests++;
        if (mac_tx_vld !== 1'b1 || gnt !== 4'b0100) begin
            fails++;
            $display("FAIL rst_launch: vld=%b gnt=%b required 1 0100", mac_tx_vld, gnt);
        end
        step;
        mac_tx_busy = 1'b1;
        for (int a = 0; a < 6; a++) begin
            step;
            mac_tx_addr = 11'(a);
        end
        reset = 1'b1;
        req = '0;
        mac_tx_busy = 1'b0;
        mac_tx_addr = '0;
        step;
        reset = 1'b0;
        tests++;
        if ({gnt, done, err, mac_tx_vld} !== '0 || mac_tx_count !== 11'd0) begin
            fails++;
            $display("FAIL rst_mid: gnt=%b done=%b err=%b vld=%b count=%0d required all 0",
                     gnt, done, err, mac_tx_vld, mac_tx_count);
        end
        m_ptr = 0;
        bad = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step;
            if (done !== '0 || gnt !== '0) bad = 1'b1;
        end
        tests++;
        if (bad) begin
            fails++;
            $display("FAIL rst_nodone: done/gnt asserted after mid-frame reset, required 0");
        end
        req = 4'b1010;
        set_last(1, 30);
        set_last(3, 70);
        run_frame(pick(req, m_ptr), 30, 1'b0, 1'b0);
        req = '0;
    endtask

    initial begin
        test_reset;
        test_rr;
        test_single;
        test_pad;
        test_random;
        test_timeout;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
